// File: rtl/vpu_fp_cmp.sv
// Pipelined IEEE-754 comparator: pairs A/B valid-only streams through one-entry
// hold registers, classifies in stage 1, and emits a registered condition code in stage 2.
module vpu_fp_cmp #(
  parameter  int EXP_W  = 8,
  parameter  int MAN_W  = 23,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              s_axis_a_tvalid,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_b_tvalid,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  output logic              m_axis_result_tvalid,
  output logic [3:0]        m_axis_result_tdata,
  output logic              m_axis_result_tuser,
  output logic              ovf_o
);

  typedef enum logic [3:0] {
    CC_GT = 4'b0001,
    CC_LT = 4'b0010,
    CC_EQ = 4'b0100,
    CC_UN = 4'b1000
  } cc_e;

  typedef struct packed {
    logic nan;
    logic snan;
    logic both_zero;
    logic sign_a;
    logic sign_b;
    logic mag_gt;
    logic mag_eq;
  } s1_t;

  logic              held_a_q, held_a_d, held_b_q, held_b_d;
  logic [DATA_W-1:0] hdata_a_q, hdata_a_d, hdata_b_q, hdata_b_d;
  logic              ovf_q, ovf_d;
  logic              s1_valid_q, s1_valid_d;
  s1_t               s1_q, s1_d;
  logic              res_valid_q, res_valid_d;
  logic [3:0]        res_data_q, res_data_d;
  logic              res_user_q, res_user_d;

  logic              issue;
  logic              keep_a, keep_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [MAN_W-1:0]  frac_a, frac_b;
  logic              nan_a, nan_b;

  // Pairing: held entries are consumed before live beats; an unconsumed live
  // beat always lands in the hold register, overwriting any older entry.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    issue  = (held_a_q | s_axis_a_tvalid) & (held_b_q | s_axis_b_tvalid);
    op_a   = held_a_q ? hdata_a_q : s_axis_a_tdata;
    op_b   = held_b_q ? hdata_b_q : s_axis_b_tdata;
    keep_a = s_axis_a_tvalid & ~(issue & ~held_a_q);
    keep_b = s_axis_b_tvalid & ~(issue & ~held_b_q);

    held_a_d  = keep_a | (held_a_q & ~issue);
    held_b_d  = keep_b | (held_b_q & ~issue);
    hdata_a_d = keep_a ? s_axis_a_tdata : hdata_a_q;
    hdata_b_d = keep_b ? s_axis_b_tdata : hdata_b_q;
    ovf_d     = ovf_q | (~issue & ((s_axis_a_tvalid & held_a_q) |
                                   (s_axis_b_tvalid & held_b_q)));
  end

  always_comb begin
    exp_a  = op_a[DATA_W-2 -: EXP_W];
    exp_b  = op_b[DATA_W-2 -: EXP_W];
    frac_a = op_a[MAN_W-1:0];
    frac_b = op_b[MAN_W-1:0];
    nan_a  = (&exp_a) & (|frac_a);
    nan_b  = (&exp_b) & (|frac_b);

    s1_valid_d     = issue;
    s1_d.nan       = nan_a | nan_b;
    s1_d.snan      = (nan_a & ~frac_a[MAN_W-1]) | (nan_b & ~frac_b[MAN_W-1]);
    s1_d.both_zero = ~(|op_a[DATA_W-2:0]) & ~(|op_b[DATA_W-2:0]);
    s1_d.sign_a    = op_a[DATA_W-1];
    s1_d.sign_b    = op_b[DATA_W-1];
    s1_d.mag_gt    = op_a[DATA_W-2:0] > op_b[DATA_W-2:0];
    s1_d.mag_eq    = op_a[DATA_W-2:0] == op_b[DATA_W-2:0];
  end

  // Stage 2 decision; outputs are forced to zero whenever no result is valid.
  always_comb begin
    res_valid_d = s1_valid_q;
    res_data_d  = '0;
    res_user_d  = 1'b0;
    if (s1_valid_q) begin
      res_user_d = s1_q.snan;
      if (s1_q.nan)                     res_data_d = CC_UN;
      else if (s1_q.both_zero)          res_data_d = CC_EQ;
      else if (s1_q.sign_a != s1_q.sign_b)
        res_data_d = s1_q.sign_a ? CC_LT : CC_GT;
      else if (s1_q.mag_eq)             res_data_d = CC_EQ;
      else if (s1_q.mag_gt ^ s1_q.sign_a) res_data_d = CC_GT;
      else                              res_data_d = CC_LT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of block ordering.
  always_ff @(posedge aclk) begin
    if (rst) begin
      held_a_q    <= 1'b0;
      held_b_q    <= 1'b0;
      ovf_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_user_q  <= 1'b0;
    end else begin
      held_a_q    <= held_a_d;
      held_b_q    <= held_b_d;
      ovf_q       <= ovf_d;
      s1_valid_q  <= s1_valid_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_user_q  <= res_user_d;
    end
  end

  // NOTE: data-only registers are left unreset; they are only ever read when
  // their companion valid/held bit is set.
  always_ff @(posedge aclk) begin
    hdata_a_q <= hdata_a_d;
    hdata_b_q <= hdata_b_d;
    s1_q      <= s1_d;
  end

  assign m_axis_result_tvalid = res_valid_q;
  assign m_axis_result_tdata  = res_data_q;
  assign m_axis_result_tuser  = res_user_q;
  assign ovf_o                = ovf_q;

endmodule

// File: tb/tb_vpu_fp_cmp.sv
// Self-checking bench for vpu_fp_cmp: directed test-plan cases plus random streams,
// checked every cycle against a real-arithmetic reference model and a timed scoreboard.
module tb_vpu_fp_cmp;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int DATA_W = 32;

  logic              aclk = 1'b0;
  logic              rst  = 1'b1;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              r_valid, r_user, ovf;
  logic [3:0]        r_data;

  vpu_fp_cmp #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .aclk                 (aclk),
    .rst                  (rst),
    .s_axis_a_tvalid      (a_valid),
    .s_axis_a_tdata       (a_data),
    .s_axis_b_tvalid      (b_valid),
    .s_axis_b_tdata       (b_data),
    .m_axis_result_tvalid (r_valid),
    .m_axis_result_tdata  (r_data),
    .m_axis_result_tuser  (r_user),
    .ovf_o                (ovf)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [4:0] res;   // {tuser, code}
  } exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0;
  bit mon_en = 1'b0;
  bit held_a = 1'b0, held_b = 1'b0;
  logic [31:0] ha = '0, hb = '0;
  bit ovf_model = 1'b0;
  int dir_cyc = -1;
  logic [4:0] dir_res = '0;
  string dir_tag = "none";
  logic [5:0] mon_got, mon_want;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Exact real value of a binary32 pattern; infinities map above every finite value.
  function automatic real fp_val(input logic [31:0] x);
    int  e;
    real m;
    e = int'(x[30:23]);
    if (e == 0) m = real'(x[22:0]) * 2.0 ** (-149);
    else        m = (real'(x[22:0]) + 2.0 ** 23) * 2.0 ** (e - 150);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [4:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    bit  na, nb, sa, sb;
    real ra, rb;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sa = na && !a[22];
    sb = nb && !b[22];
    if (na || nb) return {sa | sb, 4'b1000};
    ra = fp_val(a);
    rb = fp_val(b);
    if (ra > rb)      return 5'b0_0001;
    else if (ra < rb) return 5'b0_0010;
    else              return 5'b0_0100;
  endfunction

  // Drive one cycle of stimulus and advance the pairing model by one edge.
  task automatic drive(input bit r, input bit va, input logic [31:0] da,
                       input bit vb, input logic [31:0] db);
    bit issue, ovf_nx;
    logic [31:0] oa, ob;
    rst = r; a_valid = va; a_data = da; b_valid = vb; b_data = db;
    ovf_nx = ovf_model;
    if (r) begin
      held_a = 1'b0;
      held_b = 1'b0;
      ovf_nx = 1'b0;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end else begin
      issue = (held_a || va) && (held_b || vb);
      if (issue) begin
        oa = held_a ? ha : da;
        ob = held_b ? hb : db;
        q.push_back('{cyc + 2, ref_cmp(oa, ob)});
        if (held_a) begin if (va) ha = da; else held_a = 1'b0; end
        if (held_b) begin if (vb) hb = db; else held_b = 1'b0; end
      end else begin
        if (va) begin if (held_a) ovf_nx = 1'b1; held_a = 1'b1; ha = da; end
        if (vb) begin if (held_b) ovf_nx = 1'b1; held_b = 1'b1; hb = db; end
      end
    end
    @(posedge aclk);
    #1;
    ovf_model = ovf_nx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] res);
    dir_tag = tag; dir_cyc = cyc + 2; dir_res = res;
    drive(1'b0, 1'b1, a, 1'b1, b);
    idle(3);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x = {x[31], 31'h0};
      1: x = {x[31], 8'hFF, 23'h0};
      2: x = {x[31], 8'hFF, 1'b1, x[21:0]};
      3: x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
      4: x = {x[31], 8'h00, x[22:0]};
      5: x = {x[31], 31'h3F800000};
      6: x = {x[31], 8'h80, 19'h0, x[3:0]};
      default: ;
    endcase
    return x;
  endfunction

  always @(negedge aclk) begin
    if (mon_en) begin
      mon_got  = {r_valid, r_user, r_data};
      mon_want = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_want = {1'b1, q[0].res};
        void'(q.pop_front());
      end
      check("result", {26'h0, mon_got}, {26'h0, mon_want});
      check("ovf", {31'h0, ovf}, {31'h0, ovf_model});
      if (cyc == dir_cyc) check(dir_tag, {26'h0, mon_got}, {26'h0, 1'b1, dir_res});
    end
  end

  initial begin
    drive(1'b1, 1'b1, 32'h3F800000, 1'b1, 32'h3F800000);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("reset_state", {28'h0, r_valid, r_user, ovf, |r_data}, 32'h0);
    mon_en = 1'b1;
    idle(1);

    directed("gt_3_2",      32'h40400000, 32'h40000000, 5'b0_0001);
    directed("lt_2_3",      32'h40000000, 32'h40400000, 5'b0_0010);
    directed("zero_eq",     32'h80000000, 32'h00000000, 5'b0_0100);
    directed("neg_order",   32'hBF800000, 32'hC0000000, 5'b0_0001);
    directed("ninf_subn",   32'hFF800000, 32'h00000001, 5'b0_0010);
    directed("qnan",        32'h7FC00000, 32'h3F800000, 5'b0_1000);
    directed("snan",        32'h7F800001, 32'h3F800000, 5'b1_1000);

    dir_tag = "stagger"; dir_cyc = cyc + 5; dir_res = 5'b0_0010;
    drive(1'b0, 1'b1, 32'h3F800000, 1'b0, '0);
    idle(2);
    drive(1'b0, 1'b0, '0, 1'b1, 32'h40000000);
    idle(3);

    check("ovf_clear", {31'h0, ovf}, 32'h0);
    dir_tag = "ovf_newest"; dir_cyc = cyc + 4; dir_res = 5'b0_0001;
    drive(1'b0, 1'b1, 32'h40A00000, 1'b0, '0);
    drive(1'b0, 1'b1, 32'h40E00000, 1'b0, '0);
    check("ovf_set", {31'h0, ovf}, 32'h1);
    drive(1'b0, 1'b0, '0, 1'b1, 32'h40C00000);
    idle(3);

    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, rnd_op(), 1'b1, rnd_op());
    idle(3);

    drive(1'b0, 1'b1, 32'h40400000, 1'b1, 32'h40000000);
    drive(1'b1, 1'b1, 32'h40000000, 1'b1, 32'h40400000);
    check("rst_flush", {28'h0, r_valid, r_user, ovf, |r_data}, 32'h0);
    idle(2);
    directed("after_rst",   32'hC0000000, 32'hBF800000, 5'b0_0010);

    for (int i = 0; i < 500; i++)
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 6, rnd_op(),
            $urandom_range(0, 9) < 6, rnd_op());
    idle(4);
    check("drain", q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
